dma_xfer_engine: RTL and testbench



---
 rtl/dma_pkg.sv | 75 +++++++
 rtl/dma_xfer_engine.sv | 212 +++++++++++++++++++++
 tb/tb_dma_xfer_engine.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_pkg.sv
// Shared definitions for the DMA transfer engine and the DMA configuration block:
// FSM state encoding, item-count width, register map and OBI manager port types.
package dma_pkg;

  localparam int unsigned ITEM_W = 11;

  // Register offsets of the DMA configuration block.
  localparam logic [7:0] REG_CTRL_OFFSET   = 8'h00;
  localparam logic [7:0] REG_SRC_OFFSET    = 8'h04;
  localparam logic [7:0] REG_DST_OFFSET    = 8'h08;
  localparam logic [7:0] REG_STRIDE_OFFSET = 8'h0C;
  localparam logic [7:0] REG_REPEAT_OFFSET = 8'h10;
  localparam logic [7:0] REG_STATUS_OFFSET = 8'h14;
  localparam logic [7:0] REG_ITEMS_OFFSET  = 8'h18;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    WR_WAIT = 3'd4,
    DONE    = 3'd5
  } dma_state_e;

  typedef struct packed {
    logic [31:0] addr_width;
    logic [31:0] data_width;
    logic [31:0] id_width;
    logic        use_rready;
  } obi_cfg_t;

  localparam obi_cfg_t ObiDefaultConfig = '{
    addr_width: 32'd32,
    data_width: 32'd32,
    id_width:   32'd1,
    use_rready: 1'b0
  };

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        aid;
  } obi_a_chan_t;

  typedef struct packed {
    logic        req;
    obi_a_chan_t a;
    logic        rready;
  } obi_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } obi_r_chan_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    obi_r_chan_t r;
  } obi_rsp_t;

  function automatic logic [3:0] byte_lane_be(input logic [1:0] lane);
    return 4'b0001 << lane;
  endfunction

  // Picks one byte of a word and copies it into every lane.
  function automatic logic [31:0] byte_replicate(input logic [31:0] word, input logic [1:0] lane);
    logic [31:0] shifted;
    shifted = word >> {lane, 3'b000};
    return {4{shifted[7:0]}};
  endfunction

endpackage

// File: rtl/dma_xfer_engine.sv
// Single-channel memory-to-memory copy engine: alternates one OBI read and one
// OBI write per item, with byte/word items, address stride, abort and error stop.
module dma_xfer_engine
  import dma_pkg::*;
#(
  parameter obi_cfg_t ObiCfg        = ObiDefaultConfig,
  parameter type      mgr_obi_req_t = obi_req_t,
  parameter type      mgr_obi_rsp_t = obi_rsp_t
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [31:0]       src_addr_i,
  input  logic [31:0]       dst_addr_i,
  input  logic [7:0]        stride_i,
  input  logic [10:0]       repeat_i,
  input  logic              byte_mode_i,
  input  logic              abort_i,
  output mgr_obi_req_t      mgr_req_o,
  input  mgr_obi_rsp_t      mgr_rsp_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [ITEM_W-1:0] items_done_o
);

  dma_state_e        r_state;
  logic [31:0]       r_src;
  logic [31:0]       r_dst;
  logic [7:0]        r_stride;
  logic [ITEM_W-1:0] r_repeat;
  logic              r_byte_mode;
  logic              r_abort_rd;
  logic              r_abort_pend;
  logic              r_req;
  logic              r_we;
  logic [31:0]       r_addr;
  logic [3:0]        r_be;
  logic [31:0]       r_wdata;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic [ITEM_W-1:0] r_items;

  logic [31:0]       w_next_src;
  logic [31:0]       w_next_dst;
  logic [ITEM_W-1:0] w_items_inc;
  logic              w_more;
  logic              w_misaligned;
  logic [31:0]       w_rd_word;
  logic [3:0]        w_wr_be;

  assign w_next_src   = r_src + {24'd0, r_stride};
  assign w_next_dst   = r_dst + {24'd0, r_stride};
  assign w_items_inc  = r_items + {{(ITEM_W-1){1'b0}}, 1'b1};
  // One extra bit so items+1 cannot wrap when repeat is at its maximum.
  assign w_more       = ({1'b0, r_items} + {{ITEM_W{1'b0}}, 1'b1}) < {1'b0, r_repeat};
  assign w_misaligned = !byte_mode_i && ((src_addr_i[1:0] != 2'b00) || (dst_addr_i[1:0] != 2'b00));
  assign w_rd_word    = r_byte_mode ? byte_replicate(mgr_rsp_i.r.rdata, r_src[1:0])
                                    : mgr_rsp_i.r.rdata;
  assign w_wr_be      = r_byte_mode ? byte_lane_be(r_dst[1:0]) : 4'hF;

  // Transfer sequencer; every bus field and status output is a register here.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= IDLE;
      r_src        <= 32'd0;
      r_dst        <= 32'd0;
      r_stride     <= 8'd0;
      r_repeat     <= '0;
      r_byte_mode  <= 1'b0;
      r_abort_rd   <= 1'b0;
      r_abort_pend <= 1'b0;
      r_req        <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= 32'd0;
      r_be         <= 4'h0;
      r_wdata      <= 32'd0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_items      <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start_i) begin
            r_src        <= src_addr_i;
            r_dst        <= dst_addr_i;
            r_stride     <= stride_i;
            r_repeat     <= repeat_i;
            r_byte_mode  <= byte_mode_i;
            r_abort_rd   <= 1'b0;
            r_abort_pend <= 1'b0;
            r_err        <= 1'b0;
            r_items      <= '0;
            r_busy       <= 1'b1;
            if (repeat_i == 11'd0) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else if (w_misaligned) begin
              r_err   <= 1'b1;
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= RD_REQ;
              r_req   <= 1'b1;
              r_we    <= 1'b0;
              r_addr  <= {src_addr_i[31:2], 2'b00};
              r_be    <= 4'hF;
            end
          end
        end
        RD_REQ: begin
          // An abort seen before the read is granted suppresses this item's write.
          if (abort_i) begin
            r_abort_rd <= 1'b1;
          end
          if (mgr_rsp_i.gnt) begin
            r_req   <= 1'b0;
            r_state <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (abort_i) begin
            r_abort_pend <= 1'b1;
          end
          if (mgr_rsp_i.rvalid) begin
            if (mgr_rsp_i.r.err) begin
              r_err   <= 1'b1;
              r_state <= DONE;
              r_done  <= 1'b1;
            end else if (r_abort_rd) begin
              r_wdata <= w_rd_word;
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_wdata <= w_rd_word;
              r_state <= WR_REQ;
              r_req   <= 1'b1;
              r_we    <= 1'b1;
              r_addr  <= {r_dst[31:2], 2'b00};
              r_be    <= w_wr_be;
            end
          end
        end
        WR_REQ: begin
          if (abort_i) begin
            r_abort_pend <= 1'b1;
          end
          if (mgr_rsp_i.gnt) begin
            r_req   <= 1'b0;
            r_state <= WR_WAIT;
          end
        end
        WR_WAIT: begin
          if (abort_i) begin
            r_abort_pend <= 1'b1;
          end
          if (mgr_rsp_i.rvalid) begin
            if (mgr_rsp_i.r.err) begin
              r_err   <= 1'b1;
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_items <= w_items_inc;
              r_src   <= w_next_src;
              r_dst   <= w_next_dst;
              if (w_more && !abort_i && !r_abort_pend) begin
                r_state <= RD_REQ;
                r_req   <= 1'b1;
                r_we    <= 1'b0;
                r_addr  <= {w_next_src[31:2], 2'b00};
                r_be    <= 4'hF;
              end else begin
                r_state <= DONE;
                r_done  <= 1'b1;
              end
            end
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_req   <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Bus request assembled from registered fields only.
  always_comb begin
    mgr_req_o         = '0;
    mgr_req_o.req     = r_req;
    mgr_req_o.a.addr  = r_addr;
    mgr_req_o.a.we    = r_we;
    mgr_req_o.a.be    = r_be;
    mgr_req_o.a.wdata = r_wdata;
    mgr_req_o.a.aid   = 1'b0;
    mgr_req_o.rready  = ObiCfg.use_rready ? 1'b1 : 1'b0;
  end

  assign busy_o       = r_busy;
  assign done_o       = r_done;
  assign err_o        = r_err;
  assign items_done_o = r_items;

endmodule

// File: tb/tb_dma_xfer_engine.sv
// Directed and randomized checks of dma_xfer_engine against a memory slave and an
// item-by-item copy model.
module tb_dma_xfer_engine;
  import dma_pkg::*;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] src;
  logic [31:0] dst;
  logic [7:0]  stride;
  logic [10:0] rep;
  logic        byte_mode;
  logic        abort;
  obi_req_t    req_s;
  obi_rsp_t    rsp_s;
  logic        busy;
  logic        done;
  logic        err;
  logic [10:0] items;

  int n_cmp = 0;
  int n_bad = 0;

  txn_t        log_q[$];
  txn_t        exp_q[$];
  logic [31:0] mem [logic [31:0]];
  logic [31:0] mdl_mem [logic [31:0]];
  int          exp_items;
  bit          exp_err;

  int   stall_cfg = 0;
  bit   rand_stall = 1'b0;
  bit   spur_cfg = 1'b0;
  int   err_rd_at = -1;
  int   err_wr_at = -1;
  int   rd_cnt = 0;
  int   wr_cnt = 0;
  int   stab_bad = 0;
  int   retract_bad = 0;
  bit   slv_held = 1'b0;
  bit   slv_pend = 1'b0;
  int   slv_stall = 0;
  txn_t slv_hold;
  txn_t slv_ptxn;
  txn_t slv_cur;

  always #5 clk = ~clk;

  dma_xfer_engine #(
    .ObiCfg(ObiDefaultConfig),
    .mgr_obi_req_t(obi_req_t),
    .mgr_obi_rsp_t(obi_rsp_t)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start),
    .src_addr_i(src), .dst_addr_i(dst), .stride_i(stride), .repeat_i(rep),
    .byte_mode_i(byte_mode), .abort_i(abort),
    .mgr_req_o(req_s), .mgr_rsp_i(rsp_s),
    .busy_o(busy), .done_o(done), .err_o(err), .items_done_o(items)
  );

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] merge_be(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] slv_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] mdl_rd(input logic [31:0] a);
    return mdl_mem.exists(a) ? mdl_mem[a] : init_word(a);
  endfunction

  // Memory slave: grants after a programmable stall, answers one cycle later.
  initial begin
    rsp_s = '0;
    forever begin
      @(negedge clk);
      rsp_s.rvalid = 1'b0;
      rsp_s.r.err  = 1'b0;
      rsp_s.gnt    = 1'b0;
      if (!rst_n) begin
        slv_held = 1'b0;
        slv_pend = 1'b0;
      end else begin
        if (slv_pend) begin
          slv_pend = 1'b0;
          rsp_s.rvalid = 1'b1;
          if (slv_ptxn.we) begin
            wr_cnt++;
            rsp_s.r.rdata = 32'd0;
            if (wr_cnt == err_wr_at) rsp_s.r.err = 1'b1;
            else mem[slv_ptxn.addr] = merge_be(slv_rd(slv_ptxn.addr), slv_ptxn.wdata, slv_ptxn.be);
          end else begin
            rd_cnt++;
            rsp_s.r.rdata = slv_rd(slv_ptxn.addr);
            rsp_s.r.err   = (rd_cnt == err_rd_at);
          end
        end
        if (req_s.req) begin
          slv_cur.we = req_s.a.we;       slv_cur.addr  = req_s.a.addr;
          slv_cur.be = req_s.a.be;       slv_cur.wdata = req_s.a.wdata;
          if (slv_held) begin
            if (slv_cur != slv_hold) stab_bad++;
          end else begin
            slv_held  = 1'b1;
            slv_hold  = slv_cur;
            slv_stall = rand_stall ? int'($urandom_range(0, 3)) : stall_cfg;
          end
          if (slv_stall > 0) begin
            slv_stall--;
            if (spur_cfg) begin
              rsp_s.rvalid  = 1'b1;
              rsp_s.r.err   = 1'b1;
              rsp_s.r.rdata = 32'hDEAD_BEEF;
            end
          end else begin
            rsp_s.gnt = 1'b1;
            log_q.push_back(slv_cur);
            slv_ptxn = slv_cur;
            slv_pend = 1'b1;
            slv_held = 1'b0;
          end
        end else begin
          if (slv_held) retract_bad++;
          slv_held = 1'b0;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Copy model: item i reads src+i*stride and writes dst+i*stride.
  task automatic model(input logic [31:0] s0, input logic [31:0] d0, input logic [7:0] st,
                       input logic [10:0] n, input bit bm, input int erk, input int ewk,
                       input bit stop_after_read);
    logic [31:0] s, d, w, wd;
    logic [7:0]  b;
    logic [3:0]  be;
    txn_t t;
    exp_q.delete();
    exp_items = 0;
    exp_err   = 1'b0;
    if (n == 11'd0) return;
    if (!bm && (s0[1:0] != 2'b00 || d0[1:0] != 2'b00)) begin
      exp_err = 1'b1;
      return;
    end
    for (int i = 0; i < int'(n); i++) begin
      s = s0 + 32'(i) * {24'd0, st};
      d = d0 + 32'(i) * {24'd0, st};
      t.we = 1'b0; t.addr = s & 32'hFFFF_FFFC; t.be = 4'hF; t.wdata = 32'd0;
      exp_q.push_back(t);
      if (i + 1 == erk) begin exp_err = 1'b1; return; end
      if (stop_after_read) return;
      w = mdl_rd(t.addr);
      if (bm) begin
        b  = 8'(w >> (8 * int'(s[1:0])));
        wd = {b, b, b, b};
        be = 4'(1 << int'(d[1:0]));
      end else begin
        wd = w;
        be = 4'hF;
      end
      t.we = 1'b1; t.addr = d & 32'hFFFF_FFFC; t.be = be; t.wdata = wd;
      exp_q.push_back(t);
      if (i + 1 == ewk) begin exp_err = 1'b1; return; end
      mdl_mem[t.addr] = merge_be(mdl_rd(t.addr), wd, be);
      exp_items = i + 1;
    end
  endtask

  // amode: 0 none, 1 abort from the first write wait, 2 abort raised with start.
  task automatic run_xfer(input string tag, input logic [31:0] s, input logic [31:0] d,
                          input logic [7:0] st, input logic [10:0] n, input bit bm,
                          input int stall, input bit rstall, input int erk, input int ewk,
                          input int amode, output int base);
    int dones, first_done, stab0, retr0, got;
    bit timeout, saw_wr;
    base  = log_q.size();
    stab0 = stab_bad;
    retr0 = retract_bad;
    model(s, d, st, (amode == 1 && n > 11'd0) ? 11'd1 : n, bm, erk, ewk, amode == 2);
    stall_cfg  = stall;
    rand_stall = rstall;
    err_rd_at  = (erk > 0) ? rd_cnt + erk : -1;
    err_wr_at  = (ewk > 0) ? wr_cnt + ewk : -1;
    @(negedge clk);
    src = s; dst = d; stride = st; rep = n; byte_mode = bm;
    abort = (amode == 2);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "/busy_at_start"}, 64'(busy), 64'd1);
    chk({tag, "/err_at_start"}, 64'(err), 64'(exp_err && exp_q.size() == 0 && n != 11'd0));
    dones = 0; first_done = -1; timeout = 1'b1; saw_wr = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (done) begin
        dones++;
        if (first_done < 0) first_done = cyc;
      end
      if (!busy) begin timeout = 1'b0; break; end
      if (amode == 1 && saw_wr) abort = 1'b1;
      if (req_s.req && req_s.a.we) saw_wr = 1'b1;
      @(negedge clk);
    end
    abort = 1'b0;
    chk({tag, "/timeout"}, 64'(timeout), 64'd0);
    chk({tag, "/done_pulses"}, 64'(dones), 64'd1);
    if (n == 11'd0) chk({tag, "/done_latency"}, 64'(first_done), 64'd0);
    chk({tag, "/items"}, 64'(items), 64'(exp_items));
    chk({tag, "/err"}, 64'(err), 64'(exp_err));
    chk({tag, "/req_idle"}, 64'(req_s.req), 64'd0);
    chk({tag, "/stable"}, 64'(stab_bad - stab0), 64'd0);
    chk({tag, "/no_retract"}, 64'(retract_bad - retr0), 64'd0);
    got = log_q.size() - base;
    chk({tag, "/txn_count"}, 64'(got), 64'(exp_q.size()));
    for (int i = 0; i < got && i < exp_q.size(); i++) begin
      chk($sformatf("%s/t%0d_we", tag, i), 64'(log_q[base+i].we), 64'(exp_q[i].we));
      chk($sformatf("%s/t%0d_addr", tag, i), 64'(log_q[base+i].addr), 64'(exp_q[i].addr));
      chk($sformatf("%s/t%0d_be", tag, i), 64'(log_q[base+i].be), 64'(exp_q[i].be));
      if (exp_q[i].we) chk($sformatf("%s/t%0d_wdata", tag, i), 64'(log_q[base+i].wdata), 64'(exp_q[i].wdata));
    end
  endtask

  initial begin
    int base;
    logic [31:0] rs, rd;
    logic [10:0] rn;
    bit rbm;
    int rerk, rewk;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; byte_mode = 1'b0;
    src = 32'd0; dst = 32'd0; stride = 8'd0; rep = 11'd0;
    repeat (3) @(negedge clk);
    chk("reset/req", 64'(req_s.req), 64'd0);
    chk("reset/busy", 64'(busy), 64'd0);
    chk("reset/done", 64'(done), 64'd0);
    chk("reset/err", 64'(err), 64'd0);
    chk("reset/items", 64'(items), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset/busy", 64'(busy), 64'd0);

    run_xfer("word_copy", 32'h1000_0000, 32'h1000_0100, 8'd4, 11'd3, 1'b0, 0, 1'b0, 0, 0, 0, base);

    run_xfer("byte_copy", 32'h2000_0001, 32'h2000_0102, 8'd1, 11'd2, 1'b1, 0, 1'b0, 0, 0, 0, base);
    if (log_q.size() >= base + 4) begin
      chk("byte_copy/be_first", 64'(log_q[base+1].be), 64'h4);
      chk("byte_copy/be_second", 64'(log_q[base+3].be), 64'h8);
    end else begin
      chk("byte_copy/log_len", 64'(log_q.size() - base), 64'd4);
    end

    spur_cfg = 1'b1;
    run_xfer("stall", 32'h1100_0000, 32'h1100_0800, 8'd8, 11'd2, 1'b0, 5, 1'b0, 0, 0, 0, base);
    spur_cfg = 1'b0;

    run_xfer("rd_err", 32'h1200_0000, 32'h1200_0400, 8'd4, 11'd4, 1'b0, 0, 1'b0, 2, 0, 0, base);
    run_xfer("after_err", 32'h1300_0000, 32'h1300_0400, 8'd4, 11'd2, 1'b0, 0, 1'b0, 0, 0, 0, base);
    run_xfer("wr_err", 32'h1400_0000, 32'h1400_0400, 8'd4, 11'd3, 1'b0, 1, 1'b0, 0, 2, 0, base);

    run_xfer("abort_wr", 32'h1500_0000, 32'h1500_0400, 8'd4, 11'd10, 1'b0, 0, 1'b0, 0, 0, 1, base);
    run_xfer("abort_rd", 32'h1600_0000, 32'h1600_0400, 8'd4, 11'd5, 1'b0, 3, 1'b0, 0, 0, 2, base);
    run_xfer("repeat0", 32'h1700_0000, 32'h1700_0400, 8'd4, 11'd0, 1'b0, 0, 1'b0, 0, 0, 0, base);
    run_xfer("misaligned", 32'h0000_0002, 32'h1800_0000, 8'd4, 11'd3, 1'b0, 0, 1'b0, 0, 0, 0, base);

    // Reset in the middle of a stalled read: no completion pulse may follow.
    base = log_q.size();
    stall_cfg = 5; rand_stall = 1'b0; err_rd_at = -1; err_wr_at = -1;
    @(negedge clk);
    src = 32'h1900_0000; dst = 32'h1900_0400; stride = 8'd4; rep = 11'd4; byte_mode = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("midreset/req_before", 64'(req_s.req), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset/req", 64'(req_s.req), 64'd0);
    chk("midreset/busy", 64'(busy), 64'd0);
    repeat (2) begin
      @(negedge clk);
      chk("midreset/done", 64'(done), 64'd0);
    end
    #2 rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("midreset/idle_done", 64'(done), 64'd0);
      chk("midreset/idle_busy", 64'(busy), 64'd0);
    end
    chk("midreset/no_txn", 64'(log_q.size() - base), 64'd0);

    for (int k = 0; k < 8; k++) begin
      rbm  = 1'($urandom_range(0, 1));
      rs   = 32'h3000_0000 + 32'($urandom_range(0, 255));
      rd   = 32'h3000_0000 + 32'($urandom_range(0, 255));
      if (!rbm) begin
        rs[1:0] = 2'b00;
        rd[1:0] = 2'b00;
      end
      rn   = 11'($urandom_range(1, 6));
      rerk = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0;
      rewk = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0;
      run_xfer($sformatf("rand%0d", k), rs, rd, 8'($urandom_range(0, 255)), rn, rbm,
               0, 1'b1, rerk, rewk, 0, base);
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
